// File: rtl/instr_line_fetch_if.sv
// Fetch request/response and memory burst signals of the instruction line fetch stage.
// master = CPU front end plus instruction memory; slave = the fetch stage itself.
interface instr_line_fetch_if #(
  parameter int LEN_WORD = 32
);
  logic                fetch_order;
  logic [LEN_WORD-1:0] fetch_pc;
  logic                fetch_done;
  logic [LEN_WORD-1:0] fetch_instr;
  logic [LEN_WORD-1:0] fetch_hint;
  logic                mem_req;
  logic [LEN_WORD-1:0] mem_addr;
  logic                mem_ack;
  logic                mem_valid;
  logic [LEN_WORD-1:0] mem_rdata;

  modport master (
    output fetch_order, fetch_pc, fetch_hint, mem_ack, mem_valid, mem_rdata,
    input  fetch_done, fetch_instr, mem_req, mem_addr
  );

  modport slave (
    input  fetch_order, fetch_pc, fetch_hint, mem_ack, mem_valid, mem_rdata,
    output fetch_done, fetch_instr, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_line_fetch.sv
// Instruction line fetch: zero-latency hits from demand buffer D and, when HINT_PREFETCH_EN
// is defined, a hint buffer H prefetched from fetch_hint. Lines fill by memory burst.
module instr_line_fetch #(
  parameter int LEN_WORD   = 32,
  parameter int LINE_WORDS = 8,
  parameter int LOG_LINE   = 3
) (
  input logic               clk,
  input logic               rstn,
  input logic               init,
  instr_line_fetch_if.slave bus
);
  localparam int TAG_W = LEN_WORD - LOG_LINE - 2;
  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [LOG_LINE-1:0] idx_t;
  typedef logic [LEN_WORD-1:0] word_t;
  typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
  localparam idx_t LAST = idx_t'(LINE_WORDS - 1);

  state_t state_q, state_d;
  tag_t   line_q;
  idx_t   cnt_q;
  logic   discard_q;

  logic   d_valid_q;
  tag_t   d_tag_q;
  word_t  d_data_q [LINE_WORDS];

  tag_t   pc_tag;
  idx_t   pc_idx;
  logic   d_hit, any_hit, start_demand;
  logic   unused_bits;

  assign pc_tag = bus.fetch_pc[LEN_WORD-1:LOG_LINE+2];
  assign pc_idx = bus.fetch_pc[LOG_LINE+1:2];
  assign d_hit  = d_valid_q && (d_tag_q == pc_tag);

`ifdef HINT_PREFETCH_EN
  logic   h_valid_q;
  tag_t   h_tag_q;
  word_t  h_data_q [LINE_WORDS];
  logic   tgt_h_q;
  tag_t   hint_tag;
  logic   h_hit, hint_resident, start_hint;

  assign hint_tag      = bus.fetch_hint[LEN_WORD-1:LOG_LINE+2];
  assign h_hit         = h_valid_q && (h_tag_q == pc_tag);
  assign any_hit       = d_hit || h_hit;
  assign hint_resident = (d_valid_q && (d_tag_q == hint_tag)) ||
                         (h_valid_q && (h_tag_q == hint_tag));
  assign unused_bits   = ^{bus.fetch_pc[1:0], bus.fetch_hint[1:0]};
`else
  assign any_hit       = d_hit;
  assign unused_bits   = ^{bus.fetch_pc[1:0], bus.fetch_hint};
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    start_demand = 1'b0;
`ifdef HINT_PREFETCH_EN
    start_hint   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (init) begin
          state_d = IDLE;
        end else if (bus.fetch_order && !any_hit) begin
          start_demand = 1'b1;
          state_d      = REQ;
        end
`ifdef HINT_PREFETCH_EN
        else if (!hint_resident) begin
          start_hint = 1'b1;
          state_d    = REQ;
        end
`endif
      end
      REQ: begin
        if (init)             state_d = IDLE;
        else if (bus.mem_ack) state_d = FILL;
      end
      FILL: begin
        // An init during the burst does not abort it: the remaining beats must still drain.
        if (bus.mem_valid && (cnt_q == LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.fetch_done  = 1'b0;
    bus.fetch_instr = '0;
    if (bus.fetch_order && !init) begin
      if (d_hit) begin
        bus.fetch_done  = 1'b1;
        bus.fetch_instr = d_data_q[pc_idx];
      end
`ifdef HINT_PREFETCH_EN
      else if (h_hit) begin
        bus.fetch_done  = 1'b1;
        bus.fetch_instr = h_data_q[pc_idx];
      end
`endif
    end
    bus.mem_req  = (state_q == REQ);
    bus.mem_addr = {line_q, {(LOG_LINE + 2){1'b0}}};
  end

  // NOTE: line data is reset too, so a freshly reset buffer reads as all-zero words.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_q    <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
      d_valid_q <= 1'b0;
      d_tag_q   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) d_data_q[i] <= '0;
`ifdef HINT_PREFETCH_EN
      tgt_h_q   <= 1'b0;
      h_valid_q <= 1'b0;
      h_tag_q   <= '0;
      for (int i = 0; i < LINE_WORDS; i++) h_data_q[i] <= '0;
`endif
    end else begin
      if (start_demand) begin
        line_q  <= pc_tag;
`ifdef HINT_PREFETCH_EN
        tgt_h_q <= 1'b0;
`endif
      end
`ifdef HINT_PREFETCH_EN
      if (start_hint) begin
        line_q  <= hint_tag;
        tgt_h_q <= 1'b1;
      end
`endif
      if ((state_q == REQ) && bus.mem_ack && !init) begin
        cnt_q     <= '0;
        discard_q <= 1'b0;
`ifdef HINT_PREFETCH_EN
        if (tgt_h_q) begin
          h_valid_q <= 1'b0;
          h_tag_q   <= line_q;
        end else
`endif
        begin
          d_valid_q <= 1'b0;
          d_tag_q   <= line_q;
        end
      end
      if ((state_q == FILL) && bus.mem_valid) begin
        cnt_q <= cnt_q + idx_t'(1);
`ifdef HINT_PREFETCH_EN
        if (tgt_h_q) begin
          h_data_q[cnt_q] <= bus.mem_rdata;
          if ((cnt_q == LAST) && !discard_q) h_valid_q <= 1'b1;
        end else
`endif
        begin
          d_data_q[cnt_q] <= bus.mem_rdata;
          if ((cnt_q == LAST) && !discard_q) d_valid_q <= 1'b1;
        end
      end
      // Placed last so an init on the final beat still leaves the target invalid.
      if (init) begin
        d_valid_q <= 1'b0;
`ifdef HINT_PREFETCH_EN
        h_valid_q <= 1'b0;
`endif
        if (state_q == FILL) discard_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_instr_line_fetch.sv
// Directed bench for instr_line_fetch; the hint scenarios run only when HINT_PREFETCH_EN is defined.
module tb_instr_line_fetch;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic init = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] hit_pc = 32'h40;

  always #5 clk = ~clk;

  instr_line_fetch_if #(.LEN_WORD(32)) bus ();

  instr_line_fetch #(.LEN_WORD(32), .LINE_WORDS(8), .LOG_LINE(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .init (init),
    .bus  (bus)
  );

  // Memory contents: word at byte address a is 0x1000 + (a - 0x40)/4, so line 0x40 holds 0x1000..0x1007.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h40) >> 2);
  endfunction

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bus.mem_req !== 1'b1 && n < 40);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL %s_req got=%0b exp=1 (timeout)", name, bus.mem_req);
    end
    checks++;
    if (bus.mem_addr !== exp_addr) begin
      failures++;
      $display("FAIL %s_addr got=%h exp=%h", name, bus.mem_addr, exp_addr);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] line, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = mem_word(line + 32'(4 * (first + k)));
      @(negedge clk);
    end
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    #1;
  endtask

  task automatic test_reset();
    bus.fetch_order = 1'b1;
    bus.fetch_pc    = 32'h40;
    bus.fetch_hint  = 32'h40;
    bus.mem_ack     = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_rdata   = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus.fetch_done); end
    checks++;
    if (bus.fetch_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", bus.fetch_instr); end
    checks++;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", bus.mem_req); end
    checks++;
    if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.mem_addr); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_cold_miss();
    wait_req(32'h40, "cold");
    send_beats(32'h40, 0, 3);
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL cold_partial_done got=%0b exp=0", bus.fetch_done); end
    send_beats(32'h40, 3, 5);
    checks++;
    if (bus.fetch_done !== 1'b1) begin failures++; $display("FAIL cold_done got=%0b exp=1", bus.fetch_done); end
    checks++;
    if (bus.fetch_instr !== 32'h1000) begin failures++; $display("FAIL cold_instr got=%h exp=00001000", bus.fetch_instr); end
    checks++;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL cold_req_after got=%0b exp=0", bus.mem_req); end
  endtask

  task automatic test_seq_hits();
    // Beats offered outside FILL carry junk that must never land in a buffer.
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      bus.fetch_pc  = 32'h40 + 32'(4 * i);
      bus.mem_valid = 1'b1;
      bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (bus.fetch_done !== 1'b1) begin failures++; $display("FAIL seq_done[%0d] got=%0b exp=1", i, bus.fetch_done); end
      checks++;
      if (bus.fetch_instr !== 32'h1000 + 32'(i)) begin
        failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, bus.fetch_instr, 32'h1000 + 32'(i));
      end
      checks++;
      if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL seq_req[%0d] got=%0b exp=0", i, bus.mem_req); end
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    bus.fetch_pc  = 32'h40;
    #1;
    checks++;
    if (bus.fetch_instr !== 32'h1000) begin failures++; $display("FAIL seq_stray_beat got=%h exp=00001000", bus.fetch_instr); end
  endtask

`ifdef HINT_PREFETCH_EN
  task automatic test_hint_prefetch();
    @(negedge clk);
    bus.fetch_order = 1'b0;
    bus.fetch_hint  = 32'h200;
    wait_req(32'h200, "hint");
    send_beats(32'h200, 0, 8);
    bus.fetch_order = 1'b1;
    bus.fetch_pc    = 32'h208;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b1) begin failures++; $display("FAIL hint_done got=%0b exp=1", bus.fetch_done); end
    checks++;
    if (bus.fetch_instr !== mem_word(32'h208)) begin
      failures++; $display("FAIL hint_instr got=%h exp=%h", bus.fetch_instr, mem_word(32'h208));
    end
    @(negedge clk);
    bus.fetch_pc = 32'h40;
    #1;
    checks++;
    if (bus.fetch_instr !== 32'h1000 || bus.fetch_done !== 1'b1) begin
      failures++; $display("FAIL hint_d_kept got=%h/%0b exp=00001000/1", bus.fetch_instr, bus.fetch_done);
    end
    checks++;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL hint_req_idle got=%0b exp=0", bus.mem_req); end
  endtask

  task automatic test_hint_inflight();
    @(negedge clk);
    bus.fetch_order = 1'b0;
    bus.fetch_hint  = 32'h600;
    wait_req(32'h600, "inflight_hint");
    bus.fetch_order = 1'b1;
    bus.fetch_pc    = 32'h400;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL inflight_done got=%0b exp=0", bus.fetch_done); end
    send_beats(32'h600, 0, 8);
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL inflight_wait_done got=%0b exp=0", bus.fetch_done); end
    wait_req(32'h400, "inflight_demand");
    send_beats(32'h400, 0, 8);
    checks++;
    if (bus.fetch_done !== 1'b1 || bus.fetch_instr !== mem_word(32'h400)) begin
      failures++; $display("FAIL inflight_d_hit got=%h/%0b exp=%h/1", bus.fetch_instr, bus.fetch_done, mem_word(32'h400));
    end
    @(negedge clk);
    bus.fetch_pc = 32'h60C;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b1 || bus.fetch_instr !== mem_word(32'h60C)) begin
      failures++; $display("FAIL inflight_h_hit got=%h/%0b exp=%h/1", bus.fetch_instr, bus.fetch_done, mem_word(32'h60C));
    end
    bus.fetch_hint = 32'h400;
    hit_pc = 32'h400;
  endtask
`endif

  task automatic test_init();
    @(negedge clk);
    bus.fetch_order = 1'b1;
    bus.fetch_pc    = hit_pc;
    bus.fetch_hint  = hit_pc;
    init = 1'b1;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL init_cycle_done got=%0b exp=0", bus.fetch_done); end
    @(negedge clk);
    init = 1'b0;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL init_inval_done got=%0b exp=0", bus.fetch_done); end
    wait_req(hit_pc, "init_refetch");
    send_beats(hit_pc, 0, 3);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    send_beats(hit_pc, 3, 5);
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL init_stale_done got=%0b exp=0", bus.fetch_done); end
    checks++;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL init_absorb_req got=%0b exp=0", bus.mem_req); end
    bus.fetch_pc   = 32'h40;
    bus.fetch_hint = 32'h40;
    wait_req(32'h40, "init_fresh");
    send_beats(32'h40, 0, 8);
    bus.fetch_pc = 32'h44;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b1 || bus.fetch_instr !== 32'h1001) begin
      failures++; $display("FAIL init_refill got=%h/%0b exp=00001001/1", bus.fetch_instr, bus.fetch_done);
    end
  endtask

  task automatic test_reset_midfill();
    @(negedge clk);
    bus.fetch_pc   = 32'hA00;
    bus.fetch_hint = 32'hA00;
    wait_req(32'hA00, "rstfill");
    send_beats(32'hA00, 0, 2);
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    bus.fetch_pc  = 32'h40;
    bus.fetch_hint = 32'h40;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL rstfill_req got=%0b exp=0", bus.mem_req); end
    checks++;
    if (bus.fetch_done !== 1'b0) begin failures++; $display("FAIL rstfill_done got=%0b exp=0", bus.fetch_done); end
    checks++;
    if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rstfill_addr got=%h exp=0", bus.mem_addr); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    rstn = 1'b1;
    wait_req(32'h40, "rstfill_again");
    send_beats(32'h40, 0, 8);
    checks++;
    if (bus.fetch_done !== 1'b1 || bus.fetch_instr !== 32'h1000) begin
      failures++; $display("FAIL rstfill_w0 got=%h/%0b exp=00001000/1", bus.fetch_instr, bus.fetch_done);
    end
    @(negedge clk);
    bus.fetch_pc = 32'h5C;
    #1;
    checks++;
    if (bus.fetch_done !== 1'b1 || bus.fetch_instr !== 32'h1007) begin
      failures++; $display("FAIL rstfill_w7 got=%h/%0b exp=00001007/1", bus.fetch_instr, bus.fetch_done);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
`ifdef HINT_PREFETCH_EN
    test_hint_prefetch();
    test_hint_inflight();
`endif
    test_init();
    test_reset_midfill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
endmodule
